stream_demux: RTL and testbench

Registered one-hot stream demultiplexer, the inverse of the one-hot AND-OR vector mux.
- Accepts one N-bit word per cycle on a valid/ready input stream, together with a one-hot destination select.
- Delivers the word to one of M independent output channels, each with its own valid/ready handshake and a single-entry output register.
- Sits between a shared producer and M consumers, for example fanning a shared bus out to per-lane pipelines.
- Malformed selects are discarded and counted.

---
 rtl/stream_demux_if.sv | 28 ++
 rtl/stream_demux.sv | 63 ++++++
 tb/tb_stream_demux.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one valid/ready input stream fanned out
// to M valid/ready output channels, plus the malformed-select drop counter.
interface stream_demux_if #(
    parameter int N  = 32,
    parameter int M  = 2,
    parameter int CW = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [M-1:0]   in_sel;
    logic [N-1:0]   in_data;
    logic [M-1:0]   out_valid;
    logic [M-1:0]   out_ready;
    logic [M*N-1:0] out;
    logic [CW-1:0]  drop_count;

    // Design side: consumes the input stream, produces the channel outputs.
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out, drop_count
    );

    // Environment side: producer plus the M consumers.
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out, drop_count
    );
endinterface

// File: rtl/stream_demux.sv
// Registered one-hot stream demultiplexer: routes each accepted word into the
// single-entry output register of the channel named by a one-hot select.
module stream_demux #(
    parameter int N  = 32,
    parameter int M  = 2,
    parameter int CW = 8
) (
    input logic            clk,
    input logic            rst,
    stream_demux_if.slave  bus
);
    logic [M-1:0]         valid_q, valid_d;
    logic [M-1:0][N-1:0]  data_q,  data_d;
    logic [CW-1:0]        drop_q,  drop_d;

    logic         sel_ok;
    logic [M-1:0] can_take;
    logic         accept;
    logic         drop;

    // A FULL channel can still take a word when its consumer drains it this cycle.
    assign sel_ok   = $onehot(bus.in_sel);
    assign can_take = ~valid_q | bus.out_ready;

    // Malformed selects are always consumed; in_data never feeds in_ready.
    assign bus.in_ready = sel_ok ? |(bus.in_sel & can_take) : 1'b1;
    assign accept       = bus.in_valid & bus.in_ready & sel_ok;
    assign drop         = bus.in_valid & ~sel_ok;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        valid_d = valid_q & ~bus.out_ready;
        data_d  = data_q;
        drop_d  = drop_q;
        for (int i = 0; i < M; i++) begin
            if (accept && bus.in_sel[i]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = bus.in_data;
            end
        end
        if (drop && (drop_q != {CW{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the data registers are reset as well because out must read zero after reset.
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out        = data_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (N=8, M=4): a per-cycle reference model
// and delivery scoreboard, plus directed checks with hand-computed values.
module tb_stream_demux;
    localparam int N = 8;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_demux_if #(.N(N), .M(M), .CW(8)) if_a ();
    stream_demux_if #(.N(N), .M(M), .CW(2)) if_b ();

    // Second instance shares the stimulus and only differs in counter width.
    assign if_b.in_valid  = if_a.in_valid;
    assign if_b.in_sel    = if_a.in_sel;
    assign if_b.in_data   = if_a.in_data;
    assign if_b.out_ready = if_a.out_ready;

    stream_demux #(.N(N), .M(M), .CW(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    stream_demux #(.N(N), .M(M), .CW(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    int n_tests = 0;
    int n_fail  = 0;
    int delivered = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit   [M-1:0] exp_valid = '0;
    logic [N-1:0] exp_data [M];
    int           exp_drop_a = 0;
    int           exp_drop_b = 0;
    logic [N-1:0] sbq [M][$];

    initial for (int i = 0; i < M; i++) exp_data[i] = '0;

    function automatic logic [M*N-1:0] pack_exp();
        logic [M*N-1:0] v;
        for (int i = 0; i < M; i++) v[i*N +: N] = exp_data[i];
        return v;
    endfunction

    initial begin
        int  ones;
        int  k;
        bit  rdy;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ones = $countones(if_a.in_sel);
            k = 0;
            for (int i = 0; i < M; i++) if (if_a.in_sel[i]) k = i;
            rdy = (ones == 1) ? (!exp_valid[k] || if_a.out_ready[k]) : 1'b1;

            check("model_out_valid", if_a.out_valid, exp_valid);
            check("model_out_data",  if_a.out, pack_exp());
            check("model_drop_a",    if_a.drop_count, exp_drop_a);
            check("model_drop_b",    if_b.drop_count, exp_drop_b);
            check("model_valid_b",   if_b.out_valid, exp_valid);
            if (!rst && if_a.in_valid) check("model_in_ready", if_a.in_ready, rdy);

            // Scoreboard: every handshake must deliver the oldest word sent to that channel.
            for (int i = 0; i < M; i++) begin
                if (!rst && if_a.out_valid[i] && if_a.out_ready[i]) begin
                    check("deliver_pending", sbq[i].size() > 0, 1);
                    if (sbq[i].size() > 0) begin
                        check("deliver_data", if_a.out[i*N +: N], sbq[i].pop_front());
                        delivered++;
                    end
                end
            end

            // Next-cycle state from the behavioural rules.
            if (rst) begin
                exp_valid  = '0;
                exp_drop_a = 0;
                exp_drop_b = 0;
                for (int i = 0; i < M; i++) begin
                    exp_data[i] = '0;
                    sbq[i].delete();
                end
            end else begin
                exp_valid = exp_valid & ~if_a.out_ready;
                if (if_a.in_valid && ones == 1 && rdy) begin
                    exp_valid[k] = 1'b1;
                    exp_data[k]  = if_a.in_data;
                    sbq[k].push_back(if_a.in_data);
                end
                if (if_a.in_valid && ones != 1) begin
                    if (exp_drop_a < 255) exp_drop_a++;
                    if (exp_drop_b < 3)   exp_drop_b++;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        if_a.in_valid  = 1'b1;
        if_a.in_sel    = 4'b0001;
        if_a.in_data   = 8'hFF;
        if_a.out_ready = 4'b0000;

        // Reset with a word offered: nothing may load.
        tick(); tick();
        check("rst_out_valid", if_a.out_valid, 4'b0000);
        check("rst_out",       if_a.out, 32'h0);
        check("rst_drop",      if_a.drop_count, 0);
        rst = 1'b0;
        if_a.in_valid = 1'b0;
        tick();

        // Single transfer to channel 2, then held under backpressure.
        if_a.in_valid = 1'b1; if_a.in_sel = 4'b0100; if_a.in_data = 8'hA5;
        #1 check("single_in_ready", if_a.in_ready, 1);
        tick();
        if_a.in_valid = 1'b0;
        check("single_valid", if_a.out_valid, 4'b0100);
        check("single_data",  if_a.out[23:16], 8'hA5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", if_a.out_valid, 4'b0100);
            check("hold_data",  if_a.out[23:16], 8'hA5);
        end

        // Backpressure, then same-cycle drain and refill.
        if_a.in_valid = 1'b1; if_a.in_sel = 4'b0100; if_a.in_data = 8'h3C;
        #1 check("bp_in_ready", if_a.in_ready, 0);
        tick();
        check("bp_in_ready_held", if_a.in_ready, 0);
        if_a.out_ready = 4'b0100;
        #1 check("bp_release", if_a.in_ready, 1);
        tick();
        if_a.in_valid = 1'b0; if_a.out_ready = 4'b0000;
        check("refill_valid", if_a.out_valid[2], 1);
        check("refill_data",  if_a.out[23:16], 8'h3C);
        if_a.out_ready = 4'b0100;
        tick();
        if_a.out_ready = 4'b0000;
        check("drained", if_a.out_valid, 4'b0000);

        // Full-rate streaming alternating channels 0 and 3.
        d0 = delivered;
        if_a.out_ready = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            if_a.in_valid = 1'b1;
            if_a.in_sel   = (i % 2 == 0) ? 4'b0001 : 4'b1000;
            if_a.in_data  = 8'(i);
            #1 check("stream_in_ready", if_a.in_ready, 1);
            tick();
        end
        if_a.in_valid = 1'b0;
        tick(); tick();
        check("stream_delivered", delivered - d0, 16);
        if_a.out_ready = 4'b0000;

        // Malformed selects are dropped while channel 1 stays FULL.
        if_a.in_valid = 1'b1; if_a.in_sel = 4'b0010; if_a.in_data = 8'h5A;
        tick();
        if_a.in_sel = 4'b0000; if_a.in_data = 8'h11;
        #1 check("bad0_in_ready", if_a.in_ready, 1);
        tick();
        if_a.in_sel = 4'b0011; if_a.in_data = 8'h22;
        #1 check("bad1_in_ready", if_a.in_ready, 1);
        tick();
        if_a.in_valid = 1'b0;
        check("drop_two",        if_a.drop_count, 2);
        check("drop_keep_valid", if_a.out_valid, 4'b0010);
        check("drop_keep_data",  if_a.out[15:8], 8'h5A);
        if_a.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_a.in_sel = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            tick();
        end
        if_a.in_valid = 1'b0;
        check("drop_seven",  if_a.drop_count, 7);
        check("drop_sat_cw2", if_b.drop_count, 3);

        // Reset in the middle of traffic.
        if_a.out_ready = 4'b0010;
        if_a.in_valid = 1'b1; if_a.in_sel = 4'b0001; if_a.in_data = 8'h01;
        tick();
        if_a.out_ready = 4'b0000;
        if_a.in_sel = 4'b1000; if_a.in_data = 8'h03;
        tick();
        check("pre_rst_valid", if_a.out_valid, 4'b1001);
        if_a.in_sel = 4'b0100; if_a.in_data = 8'h77;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_a.in_valid = 1'b0;
        check("midrst_valid", if_a.out_valid, 4'b0000);
        check("midrst_out",   if_a.out, 32'h0);
        check("midrst_drop",  if_a.drop_count, 0);
        if_a.in_valid = 1'b1; if_a.in_sel = 4'b0010; if_a.in_data = 8'h99;
        #1 check("resume_in_ready", if_a.in_ready, 1);
        tick();
        if_a.in_valid = 1'b0;
        check("resume_valid", if_a.out_valid, 4'b0010);
        check("resume_out",   if_a.out, 32'h0000_9900);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
